// File: rtl/exe_muldiv_if.sv
// Execute-stage multiply/divide port bundle: E-stage instruction and operands in,
// stall request and HI/LO read data out.
interface exe_muldiv_if;
    logic        flush;
    logic [31:0] Instr_E;
    logic [31:0] RS_E;
    logic [31:0] RT_E;
    logic [5:0]  EXE_In_EXC;
    logic        stall_md;
    logic [31:0] hilo_rdata;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport slave (
        input  flush, Instr_E, RS_E, RT_E, EXE_In_EXC,
        output stall_md, hilo_rdata, hi_o, lo_o
    );

    modport master (
        output flush, Instr_E, RS_E, RT_E, EXE_In_EXC,
        input  stall_md, hilo_rdata, hi_o, lo_o
    );
endinterface

// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 32 iterations per op, stalls
// the front of the pipe while busy, and serves MTHI/MTLO/MFHI/MFLO.
module exe_muldiv (
    input  logic         clk,
    input  logic         rst,
    exe_muldiv_if.slave  bus
);
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MTHI = 6'h11;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MTLO = 6'h13;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state, w_state_nx;
    logic [4:0]  r_cnt;
    logic [31:0] r_hi, r_lo;
    logic [31:0] r_a, r_b, r_rs;
    logic [31:0] r_acc_hi, r_acc_lo;
    logic        r_div, r_neg_q, r_neg_r;

    logic [5:0]  w_funct;
    logic        w_special, w_noexc, w_valid, w_is_md, w_start, w_signed;
    logic [31:0] w_rs_mag, w_rt_mag;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_sh;
    logic [33:0] w_div_diff;
    logic        w_div_ok;
    logic [31:0] w_hi_nx, w_lo_nx;
    logic [63:0] w_prod, w_prod_s;
    logic [31:0] w_fin_hi, w_fin_lo;
    logic        w_last;

    assign w_funct   = bus.Instr_E[5:0];
    assign w_special = (bus.Instr_E[31:26] == 6'd0);
    assign w_noexc   = (bus.EXE_In_EXC == 6'd0);
    assign w_valid   = w_special && w_noexc && !bus.flush;
    assign w_is_md   = (w_funct[5:2] == 4'b0110);
    assign w_start   = w_valid && (r_state == S_IDLE) && w_is_md;
    assign w_signed  = !w_funct[0];
    assign w_rs_mag  = (w_signed && bus.RS_E[31]) ? -bus.RS_E : bus.RS_E;
    assign w_rt_mag  = (w_signed && bus.RT_E[31]) ? -bus.RT_E : bus.RT_E;
    assign w_last    = (r_state == S_BUSY) && (r_cnt == 5'd31);

    assign bus.stall_md   = !rst && !bus.flush && ((r_state == S_BUSY) || w_start);
    assign bus.hi_o       = r_hi;
    assign bus.lo_o       = r_lo;

    always_comb begin
        bus.hilo_rdata = 32'd0;
        if (w_special && w_noexc) begin
            if (w_funct == F_MFHI)      bus.hilo_rdata = r_hi;
            else if (w_funct == F_MFLO) bus.hilo_rdata = r_lo;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nx = S_BUSY;
            S_BUSY:  if (r_cnt == 5'd31) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (bus.flush) w_state_nx = S_IDLE;
    end

    // Multiply: shift-add with the multiplier draining out of acc_lo as the
    // product fills in from the top. Divide: restoring, quotient shifts into acc_lo.
    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_a} : 33'd0);
    assign w_div_sh   = {r_acc_hi, r_acc_lo[31]};
    assign w_div_diff = {1'b0, w_div_sh} - {2'b00, r_b};
    assign w_div_ok   = !w_div_diff[33];

    always_comb begin
        if (r_div) begin
            w_hi_nx = w_div_ok ? w_div_diff[31:0] : w_div_sh[31:0];
            w_lo_nx = {r_acc_lo[30:0], w_div_ok};
        end else begin
            w_hi_nx = w_mul_sum[32:1];
            w_lo_nx = {w_mul_sum[0], r_acc_lo[31:1]};
        end
    end

    assign w_prod   = {w_hi_nx, w_lo_nx};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        if (!r_div) begin
            w_fin_hi = w_prod_s[63:32];
            w_fin_lo = w_prod_s[31:0];
        end else if (r_b == 32'd0) begin
            w_fin_hi = r_rs;
            w_fin_lo = 32'hFFFF_FFFF;
        end else begin
            // 0x80000000 / -1 falls out naturally: |q|=0x80000000 negates to itself
            w_fin_hi = r_neg_r ? -w_hi_nx : w_hi_nx;
            w_fin_lo = r_neg_q ? -w_lo_nx : w_lo_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_rs     <= 32'd0;
            r_acc_hi <= 32'd0;
            r_acc_lo <= 32'd0;
            r_div    <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else if (w_start) begin
            r_cnt    <= 5'd0;
            r_a      <= w_rs_mag;
            r_b      <= w_rt_mag;
            r_rs     <= bus.RS_E;
            r_acc_hi <= 32'd0;
            r_acc_lo <= w_funct[1] ? w_rs_mag : w_rt_mag;
            r_div    <= w_funct[1];
            r_neg_q  <= w_signed && (bus.RS_E[31] ^ bus.RT_E[31]);
            r_neg_r  <= w_signed && bus.RS_E[31];
        end else if (r_state == S_BUSY) begin
            r_cnt    <= r_cnt + 5'd1;
            r_acc_hi <= w_hi_nx;
            r_acc_lo <= w_lo_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_last && !bus.flush) begin
            r_hi <= w_fin_hi;
            r_lo <= w_fin_lo;
        end else if (w_valid && (r_state == S_IDLE)) begin
            if (w_funct == F_MTHI) r_hi <= bus.RS_E;
            if (w_funct == F_MTLO) r_lo <= bus.RS_E;
        end
    end
endmodule

// File: tb/tb_exe_muldiv.sv
// Directed bench for exe_muldiv: vector table of muldiv ops plus hand-written
// sequences for MT/MF, exception NOPs, flush and reset mid-operation.
module tb_exe_muldiv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    exe_muldiv_if bus();
    exe_muldiv dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [5:0] MFHI = 6'h10, MTHI = 6'h11, MFLO = 6'h12, MTLO = 6'h13;
    localparam logic [5:0] MULT = 6'h18, MULTU = 6'h19, DIV = 6'h1A, DIVU = 6'h1B;

    typedef struct {
        logic [5:0]  funct;
        logic [31:0] rs, rt, hi, lo;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    function automatic logic [31:0] mk(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a muldiv op at T0 and count stall cycles until it drops (T33).
    task automatic run_md(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                          output int ncyc);
        bus.Instr_E = mk(f);
        bus.RS_E = rs;
        bus.RT_E = rt;
        #1;
        ncyc = 0;
        while (bus.stall_md && ncyc < 100) begin
            step();
            ncyc++;
        end
    endtask

    vec_t vecs[10];
    int   ncyc;

    initial begin
        vecs[0] = '{MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vecs[4] = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[7] = '{DIVU,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[8] = '{DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        rst = 1'b1;
        bus.flush = 1'b0;
        bus.Instr_E = 32'd0;
        bus.RS_E = 32'd0;
        bus.RT_E = 32'd0;
        bus.EXE_In_EXC = 6'd0;
        step();
        chk("reset_hi", bus.hi_o, 32'd0);
        chk("reset_lo", bus.lo_o, 32'd0);
        bus.Instr_E = mk(MULT);
        #1;
        chk("reset_stall", {31'd0, bus.stall_md}, 32'd0);
        bus.Instr_E = 32'd0;
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            run_md(vecs[i].funct, vecs[i].rs, vecs[i].rt, ncyc);
            chk($sformatf("v%0d_stall_cycles", i), ncyc, 33);
            chk($sformatf("v%0d_hi", i), bus.hi_o, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), bus.lo_o, vecs[i].lo);
            step();
            bus.Instr_E = mk(MFLO);
            #1;
            chk($sformatf("v%0d_mflo", i), bus.hilo_rdata, vecs[i].lo);
            chk($sformatf("v%0d_mflo_stall", i), {31'd0, bus.stall_md}, 32'd0);
            step();
            bus.Instr_E = mk(MFHI);
            #1;
            chk($sformatf("v%0d_mfhi", i), bus.hilo_rdata, vecs[i].hi);
            step();
        end

        // MTHI/MTLO then MF* in the following cycle
        bus.Instr_E = mk(MTHI);
        bus.RS_E = 32'h12345678;
        #1;
        chk("mthi_stall", {31'd0, bus.stall_md}, 32'd0);
        step();
        bus.Instr_E = mk(MFHI);
        #1;
        chk("mfhi_after_mthi", bus.hilo_rdata, 32'h12345678);
        step();
        bus.Instr_E = mk(MTLO);
        bus.RS_E = 32'h0BADBEEF;
        step();
        bus.Instr_E = mk(MFLO);
        #1;
        chk("mflo_after_mtlo", bus.hilo_rdata, 32'h0BADBEEF);
        chk("mfhi_kept", bus.hi_o, 32'h12345678);
        step();

        // Excepting MULT is a NOP; excepting MFHI reads 0
        bus.Instr_E = mk(MULT);
        bus.RS_E = 32'd5;
        bus.RT_E = 32'd6;
        bus.EXE_In_EXC = 6'h04;
        #1;
        chk("exc_stall", {31'd0, bus.stall_md}, 32'd0);
        for (int i = 0; i < 5; i++) step();
        chk("exc_stall_later", {31'd0, bus.stall_md}, 32'd0);
        chk("exc_hi", bus.hi_o, 32'h12345678);
        chk("exc_lo", bus.lo_o, 32'h0BADBEEF);
        bus.Instr_E = mk(MFHI);
        #1;
        chk("exc_mfhi", bus.hilo_rdata, 32'd0);
        bus.EXE_In_EXC = 6'd0;
        bus.Instr_E = 32'd0;
        step();

        // Flush in BUSY cycle 10 of a DIV
        bus.Instr_E = mk(DIV);
        bus.RS_E = 32'd100;
        bus.RT_E = 32'd3;
        for (int i = 0; i < 10; i++) step();
        chk("flush_pre_stall", {31'd0, bus.stall_md}, 32'd1);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, bus.stall_md}, 32'd0);
        step();
        bus.flush = 1'b0;
        bus.Instr_E = 32'd0;
        #1;
        chk("flush_next_stall", {31'd0, bus.stall_md}, 32'd0);
        for (int i = 0; i < 40; i++) step();
        chk("flush_hi", bus.hi_o, 32'h12345678);
        chk("flush_lo", bus.lo_o, 32'h0BADBEEF);
        run_md(DIV, 32'd100, 32'd3, ncyc);
        chk("post_flush_cycles", ncyc, 33);
        chk("post_flush_hi", bus.hi_o, 32'd1);
        chk("post_flush_lo", bus.lo_o, 32'd33);
        step();
        bus.Instr_E = 32'd0;
        step();

        // Flush on the final BUSY cycle must not write HI/LO
        bus.Instr_E = mk(MULTU);
        bus.RS_E = 32'd9;
        bus.RT_E = 32'd9;
        for (int i = 0; i < 32; i++) step();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        bus.Instr_E = 32'd0;
        step();
        chk("late_flush_hi", bus.hi_o, 32'd1);
        chk("late_flush_lo", bus.lo_o, 32'd33);

        // Reset mid-BUSY
        bus.Instr_E = mk(MULT);
        bus.RS_E = 32'd11;
        bus.RT_E = 32'd13;
        for (int i = 0; i < 5; i++) step();
        chk("midrst_pre_stall", {31'd0, bus.stall_md}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_stall", {31'd0, bus.stall_md}, 32'd0);
        chk("midrst_hi", bus.hi_o, 32'd0);
        chk("midrst_lo", bus.lo_o, 32'd0);
        bus.Instr_E = 32'd0;
        step();
        rst = 1'b0;
        step();
        run_md(MULT, 32'd11, 32'd13, ncyc);
        chk("post_rst_cycles", ncyc, 33);
        chk("post_rst_lo", bus.lo_o, 32'd143);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
